apbm_ms: RTL and testbench

APBM_MS -- requirements
Module: apbm_ms

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apbm_wdog.sv | 35 +++
 rtl/apbm_ms.sv | 215 +++++++++++++++++++++
 tb/tb_apbm_ms.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: state encoding and response codes shared by the APB master and its helpers.
package apb_pkg;

  // Transfer sequencing states of the master.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apbm_state_e;

  // Response codes returned on rsp_err.
  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT = 2'd2;
  localparam logic [1:0] RSP_DECERR  = 2'd3;

  // Map a slave's error flag to the response code of a normally completed transfer.
  function automatic logic [1:0] completion_code(input logic slverr);
    logic [1:0] code;
    if (slverr) begin
      code = RSP_SLVERR;
    end else begin
      code = RSP_OK;
    end
    return code;
  endfunction

endpackage

// File: rtl/apbm_wdog.sv
// apbm_wdog: counts ACCESS cycles that end without pready; expired flags the
// cycle that completes the TIMEOUT budget so the master can abort on that edge.
module apbm_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic apb_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Count value seen during the TIMEOUT-th waiting cycle.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Cycle counter: cleared outside ACCESS, saturates at LAST.
  always_ff @(posedge apb_clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Decode of the counter register only; the master consults it in ACCESS.
  assign expired = (count_r == LAST);

endmodule

// File: rtl/apbm_ms.sv
// apbm_ms: single-outstanding APB master with slave decode on the upper address
// bits, wait-state timeout and a held response channel.
module apbm_ms
  import apb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 16,
  parameter int NSLV     = 4,
  parameter int SELBITS  = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                      apb_clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDRBITS-1:0]       req_addr,
  input  logic [WIDTH-1:0]          req_wdata,
  input  logic [WIDTH/8-1:0]        req_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [NSLV-1:0]           psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRBITS-1:0]       paddr,
  output logic [WIDTH-1:0]          pwdata,
  output logic [WIDTH/8-1:0]        pstrb,
  input  logic [NSLV*WIDTH-1:0]     prdata,
  input  logic [NSLV-1:0]           pready,
  input  logic [NSLV-1:0]           pslverr
);

  localparam int SW = WIDTH / 8;
  localparam logic [SELBITS:0] NSLV_L = (SELBITS + 1)'(NSLV);

  apbm_state_e            state_r, state_nx_s;
  logic [NSLV-1:0]        psel_r, psel_nx_s;
  logic                   penable_r, penable_nx_s;
  logic                   pwrite_r, pwrite_nx_s;
  logic [ADDRBITS-1:0]    paddr_r, paddr_nx_s;
  logic [WIDTH-1:0]       pwdata_r, pwdata_nx_s;
  logic [SW-1:0]          pstrb_r, pstrb_nx_s;
  logic                   rsp_valid_r, rsp_valid_nx_s;
  logic [WIDTH-1:0]       rsp_rdata_r, rsp_rdata_nx_s;
  logic [1:0]             rsp_err_r, rsp_err_nx_s;

  logic [SELBITS-1:0]     idx_s;
  logic                   dec_ok_s;
  logic [NSLV-1:0]        sel_oh_s;
  logic [WIDTH-1:0]       sel_rdata_s;
  logic                   sel_ready_s;
  logic                   sel_err_s;
  logic                   wd_clear_s;
  logic                   wd_enable_s;
  logic                   wd_expired_s;

  // Slave index from the top address bits; indices past NSLV are a decode error.
  assign idx_s    = req_addr[ADDRBITS-1 -: SELBITS];
  assign dec_ok_s = ({1'b0, idx_s} < NSLV_L);

  // One-hot select for the requested slave.
  always_comb begin
    sel_oh_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_oh_s[i] = (idx_s == SELBITS'(i));
    end
  end

  // Return path from the slave currently selected by psel; others are masked off.
  always_comb begin
    sel_rdata_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_rdata_s = sel_rdata_s | (prdata[i*WIDTH +: WIDTH] & {WIDTH{psel_r[i]}});
    end
  end

  assign sel_ready_s = |(pready & psel_r);
  assign sel_err_s   = |(pslverr & psel_r);

  assign wd_clear_s  = (state_r != ST_ACCESS);
  assign wd_enable_s = (state_r == ST_ACCESS) && !sel_ready_s;

  apbm_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .apb_clk (apb_clk),
    .reset   (reset),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_nx_s     = state_r;
    psel_nx_s      = psel_r;
    penable_nx_s   = penable_r;
    pwrite_nx_s    = pwrite_r;
    paddr_nx_s     = paddr_r;
    pwdata_nx_s    = pwdata_r;
    pstrb_nx_s     = pstrb_r;
    rsp_valid_nx_s = rsp_valid_r;
    rsp_rdata_nx_s = rsp_rdata_r;
    rsp_err_nx_s   = rsp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          pwrite_nx_s = req_write;
          paddr_nx_s  = req_addr;
          pwdata_nx_s = req_wdata;
          pstrb_nx_s  = req_write ? req_strb : {SW{1'b0}};
          if (dec_ok_s) begin
            psel_nx_s    = sel_oh_s;
            penable_nx_s = 1'b0;
            state_nx_s   = ST_SETUP;
          end else begin
            psel_nx_s      = '0;
            rsp_valid_nx_s = 1'b1;
            rsp_rdata_nx_s = '0;
            rsp_err_nx_s   = RSP_DECERR;
            state_nx_s     = ST_RESP;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_nx_s = 1'b1;
        state_nx_s   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready wins over an expiry landing in the same cycle.
        if (sel_ready_s) begin
          psel_nx_s      = '0;
          penable_nx_s   = 1'b0;
          rsp_valid_nx_s = 1'b1;
          rsp_rdata_nx_s = pwrite_r ? {WIDTH{1'b0}} : sel_rdata_s;
          rsp_err_nx_s   = completion_code(sel_err_s);
          state_nx_s     = ST_RESP;
        end else if (wd_expired_s) begin
          psel_nx_s      = '0;
          penable_nx_s   = 1'b0;
          rsp_valid_nx_s = 1'b1;
          rsp_rdata_nx_s = '0;
          rsp_err_nx_s   = RSP_TIMEOUT;
          state_nx_s     = ST_RESP;
        end else begin
          state_nx_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx_s = 1'b0;
          state_nx_s     = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: begin
        state_nx_s     = ST_IDLE;
        psel_nx_s      = '0;
        penable_nx_s   = 1'b0;
        rsp_valid_nx_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge apb_clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Output registers for the APB bus and the response channel.
  always_ff @(posedge apb_clk) begin
    if (reset) begin
      psel_r      <= '0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= '0;
      pwdata_r    <= '0;
      pstrb_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= RSP_OK;
    end else begin
      psel_r      <= psel_nx_s;
      penable_r   <= penable_nx_s;
      pwrite_r    <= pwrite_nx_s;
      paddr_r     <= paddr_nx_s;
      pwdata_r    <= pwdata_nx_s;
      pstrb_r     <= pstrb_nx_s;
      rsp_valid_r <= rsp_valid_nx_s;
      rsp_rdata_r <= rsp_rdata_nx_s;
      rsp_err_r   <= rsp_err_nx_s;
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign psel      = psel_r;
  assign penable   = penable_r;
  assign pwrite    = pwrite_r;
  assign paddr     = paddr_r;
  assign pwdata    = pwdata_r;
  assign pstrb     = pstrb_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apbm_ms.sv
// tb_apbm_ms: scoreboard bench for apbm_ms with a behavioural slave model.
module tb_apbm_ms;

  localparam int WIDTH = 32;
  localparam int ADDRBITS = 16;
  localparam int NSLV = 4;
  localparam int SELBITS = 3;
  localparam int TO = 4;

  logic               apb_clk = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               req_write = 1'b0;
  logic [15:0]        req_addr = 16'h0;
  logic [31:0]        req_wdata = 32'h0;
  logic [3:0]         req_strb = 4'h0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [31:0]        rsp_rdata;
  logic [1:0]         rsp_err;
  logic [3:0]         psel;
  logic               penable;
  logic               pwrite;
  logic [15:0]        paddr;
  logic [31:0]        pwdata;
  logic [3:0]         pstrb;
  logic [127:0]       prdata = 128'h0;
  logic [3:0]         pready = 4'h0;
  logic [3:0]         pslverr = 4'h0;

  apbm_ms #(
    .WIDTH(WIDTH), .ADDRBITS(ADDRBITS), .NSLV(NSLV), .SELBITS(SELBITS), .TIMEOUT(TO)
  ) dut (
    .apb_clk(apb_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 apb_clk = ~apb_clk;

  int cyc = 0;
  always @(posedge apb_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          pcyc;
    int          bp;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: outcome of one request derived from the decode, wait and timeout rules.
  function automatic exp_t model(input bit w, input logic [15:0] a, input int wt,
                                 input bit er, input logic [31:0] rd, input int bp);
    exp_t e;
    int idx;
    idx = int'(a) / 8192;
    e.bp = bp;
    e.acc = 0;
    if (idx >= NSLV) begin
      e.err = 2'd3; e.rdata = 32'h0; e.lat = 1; e.pcyc = 0;
    end else if (wt >= TO) begin
      e.err = 2'd2; e.rdata = 32'h0; e.lat = 2 + TO; e.pcyc = 1 + TO;
    end else begin
      e.err = er ? 2'd1 : 2'd0;
      e.rdata = w ? 32'h0 : rd;
      e.lat = 3 + wt;
      e.pcyc = 2 + wt;
    end
    return e;
  endfunction

  // Slave model: the selected slave raises pready after cfg_wait ACCESS cycles;
  // unselected slaves drive noise.
  int          cfg_wait = 0;
  logic        cfg_err = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  int          acc_cnt = 0;
  always @(negedge apb_clk) begin
    if ((psel != 4'b0) && penable) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
    for (int i = 0; i < NSLV; i++) begin
      if (psel[i]) begin
        pready[i] = (acc_cnt > cfg_wait);
        pslverr[i] = cfg_err;
        prdata[i*32 +: 32] = cfg_rdata;
      end else begin
        pready[i] = 1'($urandom);
        pslverr[i] = 1'($urandom);
        prdata[i*32 +: 32] = $urandom;
      end
    end
  end

  // Expected APB bus contents for the transfer in flight.
  logic [3:0]  cur_psel = 4'h0;
  logic [15:0] cur_paddr = 16'h0;
  logic        cur_pwrite = 1'b0;
  logic [31:0] cur_pwdata = 32'h0;
  logic [3:0]  cur_pstrb = 4'h0;

  // Monitor: APB phase checks, response pop/compare and rsp_ready backpressure.
  bit          in_rsp = 1'b0;
  int          hold = 0;
  int          psel_cnt = 0;
  int          last_hs = -10;
  logic [31:0] held_rd = 32'h0;
  logic [1:0]  held_err = 2'd0;
  always @(negedge apb_clk) begin
    exp_t e;
    if (reset) begin
      psel_cnt = 0; in_rsp = 1'b0; hold = 0;
    end else begin
      if (psel != 4'b0) begin
        check("psel", {28'h0, psel}, {28'h0, cur_psel});
        check("paddr", {16'h0, paddr}, {16'h0, cur_paddr});
        check("pwrite", {31'h0, pwrite}, {31'h0, cur_pwrite});
        check("pwdata", pwdata, cur_pwdata);
        check("pstrb", {28'h0, pstrb}, {28'h0, cur_pstrb});
        check("penable", {31'h0, penable}, (psel_cnt > 0) ? 32'd1 : 32'd0);
        psel_cnt++;
      end
      if (rsp_valid) begin
        check("req_ready_in_resp", {31'h0, req_ready}, 32'd0);
        if (!in_rsp) begin
          in_rsp = 1'b1;
          if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid expected none (cycle %0d)", cyc);
            hold = 0;
          end else begin
            e = sb_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {30'h0, rsp_err}, {30'h0, e.err});
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("psel_cycles", 32'(psel_cnt), 32'(e.pcyc));
            hold = e.bp;
          end
          held_rd = rsp_rdata;
          held_err = rsp_err;
          psel_cnt = 0;
        end else begin
          check("rsp_rdata_stable", rsp_rdata, held_rd);
          check("rsp_err_stable", {30'h0, rsp_err}, {30'h0, held_err});
        end
        if (hold > 0) begin
          rsp_ready = 1'b0;
          hold--;
        end else begin
          rsp_ready = 1'b1;
          last_hs = cyc;
        end
      end else begin
        in_rsp = 1'b0;
        rsp_ready = 1'($urandom);
      end
    end
  end

  // Driver: wait for req_ready, present one request for one cycle, push its expectation.
  task automatic issue(input bit w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int wt, input bit er,
                       input logic [31:0] rd, input int bp, input bit chk_b2b,
                       input bit no_rsp);
    int guard;
    int idx;
    exp_t e;
    guard = 0;
    @(negedge apb_clk);
    while (!req_ready && guard < 300) begin
      guard++;
      @(negedge apb_clk);
    end
    if (guard >= 300) begin
      n_cmp++; n_fail++;
      $display("FAIL req_ready_wait: got req_ready=0 for 300 cycles expected 1");
    end
    if (chk_b2b) check("b2b_accept_cycle", 32'(cyc), 32'(last_hs + 1));
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
    cfg_wait = wt; cfg_err = er; cfg_rdata = rd;
    idx = int'(a) / 8192;
    cur_psel = (idx < NSLV) ? 4'(1 << idx) : 4'h0;
    cur_paddr = a; cur_pwrite = w; cur_pwdata = d; cur_pstrb = w ? s : 4'h0;
    e = model(w, a, wt, er, rd, bp);
    e.acc = cyc;
    if (!no_rsp) sb_q.push_back(e);
    @(negedge apb_clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 16'($urandom);
    req_wdata = $urandom; req_strb = 4'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int guard;
    reset = 1'b1;
    repeat (3) @(negedge apb_clk);
    check("rst_psel", {28'h0, psel}, 32'd0);
    check("rst_penable", {31'h0, penable}, 32'd0);
    check("rst_pwrite", {31'h0, pwrite}, 32'd0);
    check("rst_paddr", {16'h0, paddr}, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_pstrb", {28'h0, pstrb}, 32'd0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {30'h0, rsp_err}, 32'd0);
    @(posedge apb_clk); #1 reset = 1'b0;
    @(negedge apb_clk);
    check("req_ready_after_reset", {31'h0, req_ready}, 32'd1);

    // Write, slave 1, zero wait states.
    issue(1'b1, 16'h2010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h55AA55AA, 0, 1'b0, 1'b0);
    // Read, slave 3, three wait states, slave error.
    issue(1'b0, 16'h6004, 32'h0BADF00D, 4'hF, 3, 1'b1, 32'h12345678, 0, 1'b1, 1'b0);
    // Decode error, idx 5.
    issue(1'b0, 16'hA000, 32'h0, 4'h0, 0, 1'b0, 32'hFFFFFFFF, 0, 1'b1, 1'b0);
    // Timeout on slave 0, then pready on the last allowed cycle.
    issue(1'b0, 16'h0040, 32'h0, 4'h0, TO, 1'b0, 32'h11112222, 0, 1'b1, 1'b0);
    issue(1'b0, 16'h0080, 32'h0, 4'h0, TO - 1, 1'b0, 32'hCAFEF00D, 0, 1'b1, 1'b0);
    // Backpressure for 5 cycles, then an immediate follow-up.
    issue(1'b1, 16'h4010, 32'hA5A5A5A5, 4'h3, 1, 1'b0, 32'h0, 5, 1'b1, 1'b0);
    issue(1'b0, 16'h2000, 32'h0, 4'h0, 0, 1'b0, 32'h76543210, 0, 1'b1, 1'b0);

    // Reset while in ACCESS: no response, bus dropped, ready again afterwards.
    issue(1'b0, 16'h4000, 32'h0, 4'h0, 10, 1'b0, 32'h99999999, 0, 1'b1, 1'b1);
    @(negedge apb_clk);
    check("penable_before_reset", {31'h0, penable}, 32'd1);
    @(posedge apb_clk); #1 reset = 1'b1;
    @(posedge apb_clk); #1 reset = 1'b0;
    @(negedge apb_clk);
    check("psel_after_mid_reset", {28'h0, psel}, 32'd0);
    check("penable_after_mid_reset", {31'h0, penable}, 32'd0);
    check("req_ready_after_mid_reset", {31'h0, req_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("no_rsp_after_mid_reset", {31'h0, rsp_valid}, 32'd0);
      @(negedge apb_clk);
    end

    // Randomized traffic.
    issue(1'b1, 16'h0004, 32'h01020304, 4'h5, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
            int'($urandom_range(0, 5)), 1'($urandom), $urandom,
            int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    guard = 0;
    while ((sb_q.size() != 0 || rsp_valid) && guard < 500) begin
      guard++;
      @(negedge apb_clk);
    end
    if (guard >= 500) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    repeat (2) @(negedge apb_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
